// File: rtl/rs_mdu_if.sv
// Scheduler-side bundle between the MDU RS line array, the shared MDU and rs_mdu_scheduler.
// The master modport is the scheduler; the slave modport is the line array / MDU side.
interface rs_mdu_if #(
    parameter int LINE_NUM  = 4,
    parameter int SEL_WIDTH = 2
);
    logic                 flush;
    logic [LINE_NUM-1:0]  line_ready;
    logic [LINE_NUM-1:0]  issue_en;
    logic [SEL_WIDTH-1:0] issue_sel;
    logic                 mdu_start;
    logic                 mdu_cancel;
    logic                 mdu_done;
    logic [LINE_NUM-1:0]  commit_en;
    logic                 busy;

    modport master (
        input  flush, line_ready, mdu_done,
        output issue_en, issue_sel, mdu_start, mdu_cancel, commit_en, busy
    );

    modport slave (
        output flush, line_ready, mdu_done,
        input  issue_en, issue_sel, mdu_start, mdu_cancel, commit_en, busy
    );
endinterface

// File: rtl/rs_mdu_scheduler.sv
// Round-robin issue scheduler for the MDU reservation station: picks one ready line,
// walks the shared MDU through start/busy/done and strobes the owner's commit.
module rs_mdu_scheduler #(
    parameter int LINE_NUM  = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    rs_mdu_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    logic [LINE_NUM-1:0]  rot_ready;
    logic [SEL_WIDTH-1:0] pick;
    logic                 pick_vld;

    // Rotate ready so bit 0 is the line at rr_ptr; the first set bit wins.
    always_comb begin
        rot_ready = LINE_NUM'({bus.line_ready, bus.line_ready} >> rr_ptr_q);
        pick      = '0;
        pick_vld  = 1'b0;
        for (int i = 0; i < LINE_NUM; i++) begin
            if (!pick_vld && rot_ready[i]) begin
                pick_vld = 1'b1;
                pick     = SEL_WIDTH'((int'(rr_ptr_q) + i) % LINE_NUM);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        if (bus.flush) begin
            // sel/rr_ptr survive a flush so the aborted line keeps its priority
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        sel_d   = pick;
                        state_d = START;
                    end
                end
                START: state_d = BUSY;
                BUSY: begin
                    if (bus.mdu_done) state_d = DONE;
                end
                DONE: begin
                    rr_ptr_d = (sel_q == SEL_WIDTH'(LINE_NUM - 1)) ? '0 : sel_q + 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobes come from the state register; flush is the only input that reaches them.
    always_comb begin
        bus.issue_en   = '0;
        bus.commit_en  = '0;
        bus.mdu_start  = (state_q == START) && !bus.flush;
        bus.issue_en[sel_q]  = bus.mdu_start;
        bus.commit_en[sel_q] = (state_q == DONE) && !bus.flush;
        bus.mdu_cancel = bus.flush && ((state_q == START) || (state_q == BUSY));
        bus.busy       = (state_q != IDLE);
        bus.issue_sel  = sel_q;
    end
endmodule

// File: tb/tb_rs_mdu_scheduler.sv
// Randomized bench for rs_mdu_scheduler; expectations come from an operation-level
// model (round-robin pointer plus expected per-phase strobes).
module tb_rs_mdu_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   rr = 0;

    rs_mdu_if #(.LINE_NUM(4), .SEL_WIDTH(2)) bus ();

    rs_mdu_scheduler #(.LINE_NUM(4), .SEL_WIDTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First ready line at or after the round-robin pointer, wrapping mod 4.
    function automatic int pick(input logic [3:0] m, input int r);
        for (int i = 0; i < 4; i++) begin
            int idx;
            idx = (r + i) % 4;
            if (((m >> idx) & 4'b1) != 4'b0) return idx;
        end
        return -1;
    endfunction

    // mode 0: plain op, 1: flush at busy cycle fc (fc==k coincides with done),
    // 2: flush in the commit cycle, 3: extra done pulse during start (k>=2).
    task automatic op(input logic [3:0] mask, input int mode, input int k, input int fc);
        int owner;
        logic [3:0] oh;
        bit flushed;
        bit fl;
        bus.line_ready = mask;
        bus.flush      = 1'b0;
        bus.mdu_done   = 1'b0;
        #1;
        chk("idle_busy", bus.busy, 0);
        chk("idle_start", bus.mdu_start, 0);
        owner = pick(mask, rr);
        oh    = 4'(1 << owner);

        tick();
        bus.line_ready = 4'($urandom);
        bus.mdu_done   = (mode == 3);
        #1;
        chk("start_pulse", bus.mdu_start, 1);
        chk("start_issue_en", bus.issue_en, oh);
        chk("start_issue_sel", bus.issue_sel, owner);
        chk("start_busy", bus.busy, 1);
        chk("start_commit", bus.commit_en, 0);

        flushed = 1'b0;
        for (int c = 1; c <= k; c++) begin
            tick();
            fl             = (mode == 1) && (c == fc);
            bus.mdu_done   = (c == k);
            bus.flush      = fl;
            bus.line_ready = 4'($urandom);
            #1;
            chk("busy_busy", bus.busy, 1);
            chk("busy_start", bus.mdu_start, 0);
            chk("busy_issue_en", bus.issue_en, 0);
            chk("busy_commit", bus.commit_en, 0);
            chk("busy_cancel", bus.mdu_cancel, fl);
            if (fl) begin
                flushed = 1'b1;
                break;
            end
        end

        if (!flushed) begin
            tick();
            bus.mdu_done   = 1'b0;
            bus.flush      = (mode == 2);
            bus.line_ready = 4'($urandom);
            #1;
            chk("done_commit", bus.commit_en, (mode == 2) ? 4'b0 : oh);
            chk("done_cancel", bus.mdu_cancel, 0);
            chk("done_busy", bus.busy, 1);
            chk("done_issue_en", bus.issue_en, 0);
            if (mode != 2) rr = (owner + 1) % 4;
        end

        tick();
        bus.flush      = 1'b0;
        bus.mdu_done   = 1'b0;
        bus.line_ready = 4'b0;
        #1;
        chk("post_busy", bus.busy, 0);
        chk("post_sel", bus.issue_sel, owner);
        chk("post_commit", bus.commit_en, 0);
        chk("post_issue_en", bus.issue_en, 0);
    endtask

    initial begin
        bus.flush      = 1'b0;
        bus.mdu_done   = 1'b0;
        bus.line_ready = 4'b1111;
        rst            = 1'b0;
        tick();
        tick();
        chk("rst_issue_en", bus.issue_en, 0);
        chk("rst_commit", bus.commit_en, 0);
        chk("rst_issue_sel", bus.issue_sel, 0);
        chk("rst_start", bus.mdu_start, 0);
        chk("rst_cancel", bus.mdu_cancel, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b1;
        rr  = 0;

        // all-ready round robin: 0,1,2,3,0
        for (int n = 0; n < 5; n++) op(4'b1111, 0, 1, 1);
        // single op on line 2, done 3 cycles after start
        op(4'b0100, 0, 3, 1);
        // flush one cycle after start, then the same line is picked again
        op(4'b0110, 1, 3, 1);
        op(4'b0110, 0, 2, 1);
        // flush coincident with done
        op(4'b1000, 1, 2, 2);
        // done in start is ignored
        op(4'b0001, 3, 2, 1);
        // flush in the commit cycle
        op(4'b0011, 2, 1, 1);

        // nothing ready: stays idle
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("hold_idle", bus.busy, 0);
            chk("hold_start", bus.mdu_start, 0);
        end

        for (int n = 0; n < 40; n++) begin
            int mode, k;
            mode = $urandom_range(0, 3);
            k    = (mode == 3) ? $urandom_range(2, 4) : $urandom_range(1, 4);
            op(4'($urandom_range(1, 15)), mode, k, $urandom_range(1, k));
        end

        // reset mid-operation: no cancel, everything back to zero
        bus.line_ready = 4'b0010;
        tick();
        bus.line_ready = 4'b0;
        tick();
        chk("midrst_busy_before", bus.busy, 1);
        rst = 1'b0;
        #1;
        chk("midrst_cancel", bus.mdu_cancel, 0);
        tick();
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_sel", bus.issue_sel, 0);
        chk("midrst_cancel_after", bus.mdu_cancel, 0);
        rst = 1'b1;
        rr  = 0;
        op(4'b1111, 0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rs_mdu_scheduler.md
# rs_mdu_scheduler

Issue scheduler for the MDU reservation station. It watches the state of every MDU RS line and selects one ready line with round-robin priority. It then sequences the shared multi-cycle MDU through start, busy and done phases, and pulses the owning line's commit strobe when the result is valid. It sits between the RS line array and the MDU, and is the only block that drives the per-line `issue_en` and `commit_en` signals.

## Interface
Parameters:
- `LINE_NUM`, default 4: number of RS lines served; must be ≥2.
- `SEL_WIDTH`, default 2: width of the line index; must be ≥ clog2(`LINE_NUM`).

Ports:
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `flush`  in  1: pipeline flush, active-high; aborts any in-flight operation.
- `line_ready`  in  `LINE_NUM`: bit i set when line i is in READY state (both operands resolved).
- `issue_en`  out  `LINE_NUM`: one-hot pulse to the selected line; the line moves to WAIT.
- `issue_sel`  out  `SEL_WIDTH`: index of the owning line; the datapath uses it to mux operands and opgen into the MDU.
- `mdu_start`  out  1: one-cycle start pulse to the MDU.
- `mdu_cancel`  out  1: one-cycle abort pulse to the MDU.
- `mdu_done`  in  1: MDU result valid, one-cycle pulse.
- `commit_en`  out  `LINE_NUM`: one-hot pulse that writes the MDU result into the owning line.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
States are IDLE(0), START(1), BUSY(2) and DONE(3), held in a 2-bit register. Registers: `state`, `sel` (`SEL_WIDTH`) and `rr_ptr` (`SEL_WIDTH`).

- IDLE:
  - If `line_ready` is nonzero and `flush` is 0, choose the first set bit scanning `rr_ptr`, `rr_ptr`+1, …, wrapping modulo `LINE_NUM`.
  - Latch the chosen index into `sel` and go to START.
  - Otherwise stay in IDLE.
- START:
  - Assert `mdu_start`=1 and `issue_en[sel]`=1 for this cycle only, then go to BUSY.
  - `mdu_done` is ignored in START, so the MDU latency must be ≥1 cycle.
- BUSY:
  - Hold until `mdu_done`=1, then go to DONE.
  - `line_ready` changes are ignored; there is no new selection while BUSY.
- DONE:
  - Assert `commit_en[sel]`=1 for this cycle only.
  - Set `rr_ptr` to (`sel`+1) mod `LINE_NUM`, wrapping from `LINE_NUM`-1 to 0, and go to IDLE.
- `issue_sel` equals `sel` in every state.
- `issue_en`, `commit_en`, `mdu_start` and `mdu_cancel` are decoded from `state`/`sel`, with no combinational path from the inputs. The exception is the `flush` gating described under Timing.
- Only one operation is in flight at a time. The block never issues two lines in parallel.
- Fairness: after line i commits, line i has the lowest priority for the next selection.

## Timing
- Reset (`rst`=0 at an edge): the next cycle shows `state`=IDLE, `sel`=0 and `rr_ptr`=0. All outputs are 0: `issue_en`, `commit_en`, `issue_sel`, `mdu_start`, `mdu_cancel` and `busy`. Reset mid-operation drops the operation and does not pulse `mdu_cancel`.
- Latency: `line_ready` sampled at edge t, then `mdu_start` and `issue_en` in cycle t+1. With `mdu_done` at cycle t+1+k (k≥1), `commit_en` follows in cycle t+2+k. The minimum is 4 cycles from the edge where `line_ready` is seen back to IDLE.
- Flush, which has priority over everything except reset:
  - In the cycle `flush`=1, `issue_en`, `commit_en` and `mdu_start` are forced to 0.
  - At that edge `state` goes to IDLE. `rr_ptr` and `sel` are unchanged.
  - If the state was START or BUSY, `mdu_cancel`=1 in the cycle `flush` is high.
  - A `mdu_done` that arrives in the same cycle as `flush` is discarded and produces no commit.
- Back-to-back: from DONE the block returns to IDLE, and a line that is still ready is selected on the following edge. Each operation therefore carries one IDLE bubble.
- Selection when `line_ready` is all ones: `sel` = `rr_ptr`.

## Test plan
- Reset with `rst`=0 for 2 cycles and `line_ready`=4'b1111 → every output is 0. On release, `mdu_start` in cycle 2 after release with `issue_sel`=0 and `issue_en`=4'b0001.
- Single op: `line_ready`=4'b0100, MDU returns `mdu_done` 3 cycles after start → `issue_en`=4'b0100 for exactly 1 cycle, then `commit_en`=4'b0100 exactly 1 cycle after done. `busy` is high for 5 cycles.
- Round-robin: `line_ready` held at 4'b1111 over 5 operations → issue order 0,1,2,3,0. `rr_ptr` wraps from 3 to 0.
- Flush in BUSY: flush 1 cycle after start → `mdu_cancel`=1 in that cycle, no `commit_en`, `state` back at IDLE, `rr_ptr` unchanged. The next issue selects the same line again if it is still ready.
- Flush coincident with `mdu_done` → `commit_en` stays 0 and `mdu_cancel`=1.
- Done ignored in START: `mdu_done` pulsed in the START cycle and again 2 cycles later → exactly one `commit_en`, aligned to the second pulse.
